rv32i_decode_stage: RTL and testbench

Registered, handshaked RV32I decode stage for the core pipeline, between instruction fetch and register-file read / execute. It splits each 32-bit instruction into register addresses and function fields, generates the sign-extended immediate for every base format, classifies the format, and flags illegal encodings. It is a 1-cycle pipeline stage with valid/ready flow control, an optional 2-entry skid buffer and a synchronous flush.

---
 rtl/rv32i_decode_stage_if.sv | 37 +++
 rtl/rv32i_decode_stage.sv | 157 +++++++++++++++
 tb/tb_rv32i_decode_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_decode_stage_if.sv
// rtl/rv32i_decode_stage_if.sv - handshake bundle between fetch, decode stage and execute
// Signals:
//   in_valid/in_ready/in_instr/in_pc : instruction offered by fetch into the stage
//   out_valid/out_ready/out_*        : decoded entry offered by the stage to execute
// Modports: slave = the decode stage, master = the pipeline side driving it.
interface rv32i_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [31:0]     out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
           out_rs1, out_rs2, out_funct7, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
           out_rs1, out_rs2, out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/rv32i_decode_stage.sv
// rtl/rv32i_decode_stage.sv - registered, handshaked RV32I instruction decode stage
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   flush : synchronous discard of all held entries
//   bus   : slave side of rv32i_decode_stage_if (fetch input, decoded output)
// Parameters: PC_W = PC width, SKID = 1 for 2-entry skid buffer, 0 for single register.
module rv32i_decode_stage #(
  parameter int PC_W = 32,
  parameter bit SKID = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  rv32i_decode_stage_if.slave    bus
);
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  // Only the decoded products are stored; raw fields are re-sliced from instr.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [31:0]     imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [31:0] w_i;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm;
  logic [2:0]  w_fmt;
  logic        w_illegal;
  entry_t      w_new;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_main_free;

  entry_t      r_main;
  entry_t      r_skid;
  logic        r_main_valid;
  logic        r_skid_valid;

  assign w_i   = bus.in_instr;
  assign w_opc = w_i[6:0];
  assign w_f3  = w_i[14:12];
  assign w_f7  = w_i[31:25];

  always_comb begin
    w_fmt     = FMT_X;
    w_illegal = 1'b0;
    w_imm     = '0;
    case (w_opc)
      7'b0110011: begin
        w_fmt = FMT_R;
        if (w_f7 == 7'h20) w_illegal = !(w_f3 == 3'b000 || w_f3 == 3'b101);
        else               w_illegal = (w_f7 != 7'h00);
      end
      7'b0010011: begin
        w_fmt = FMT_I;
        w_imm = {{20{w_i[31]}}, w_i[31:20]};
        // Shift-immediates reuse the upper bits as funct7.
        if (w_f3 == 3'b001)      w_illegal = (w_f7 != 7'h00);
        else if (w_f3 == 3'b101) w_illegal = (w_f7 != 7'h00 && w_f7 != 7'h20);
      end
      7'b0000011: begin
        w_fmt     = FMT_I;
        w_imm     = {{20{w_i[31]}}, w_i[31:20]};
        w_illegal = (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111);
      end
      7'b1100111: begin
        w_fmt     = FMT_I;
        w_imm     = {{20{w_i[31]}}, w_i[31:20]};
        w_illegal = (w_f3 != 3'b000);
      end
      7'b1110011, 7'b0001111: begin
        w_fmt = FMT_I;
        w_imm = {{20{w_i[31]}}, w_i[31:20]};
      end
      7'b0100011: begin
        w_fmt     = FMT_S;
        w_imm     = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
        w_illegal = (w_f3 >= 3'b011);
      end
      7'b1100011: begin
        w_fmt     = FMT_B;
        w_imm     = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
        w_illegal = (w_f3 == 3'b010 || w_f3 == 3'b011);
      end
      7'b0110111, 7'b0010111: begin
        w_fmt = FMT_U;
        w_imm = {w_i[31:12], 12'b0};
      end
      7'b1101111: begin
        w_fmt = FMT_J;
        w_imm = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) w_imm = '0;
  end

  assign w_new = {bus.in_pc, w_i, w_imm, w_fmt, w_illegal};

  // With the skid buffer, readiness depends only on local state so the
  // upstream ready path is registered; without it, it follows out_ready.
  assign w_in_ready  = SKID ? !r_skid_valid : (!r_main_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready && !flush;
  assign w_main_free = !r_main_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      // A held skid entry is older than anything upstream; it always goes first.
      // in_ready is low whenever the skid is occupied, so no accept competes here.
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) r_main <= w_new;
      end
    end else if (w_accept) begin
      // Main is stalled; only reachable with SKID=1.
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_main_valid;
  assign bus.out_pc      = r_main.pc;
  assign bus.out_opcode  = r_main.instr[6:0];
  assign bus.out_rd      = r_main.instr[11:7];
  assign bus.out_funct3  = r_main.instr[14:12];
  assign bus.out_rs1     = r_main.instr[19:15];
  assign bus.out_rs2     = r_main.instr[24:20];
  assign bus.out_funct7  = r_main.instr[31:25];
  assign bus.out_imm     = r_main.imm;
  assign bus.out_fmt     = r_main.fmt;
  assign bus.out_illegal = r_main.illegal;
endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb/tb_rv32i_decode_stage.sv - bench for rv32i_decode_stage, SKID=1 and SKID=0 instances
module tb_rv32i_decode_stage;
  typedef logic [99:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush1;
  logic flush0;
  int   n_pass  = 0;
  int   n_total = 0;

  rv32i_decode_stage_if #(.PC_W(32)) b1 ();
  rv32i_decode_stage_if #(.PC_W(32)) b0 ();

  rv32i_decode_stage #(.PC_W(32), .SKID(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(b1));
  rv32i_decode_stage #(.PC_W(32), .SKID(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .bus(b0));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode from the ISA rules: positive legality lists and
  // arithmetic-shift immediate assembly.
  function automatic vec_t ref_vec(logic [31:0] instr, logic [31:0] pc);
    int          f3;
    int          f7;
    int          fmt;
    bit          legal;
    logic [31:0] imm;
    logic signed [31:0] s;
    logic [31:0] t20;
    logic [31:0] t25;
    logic [31:0] t31;
    f3  = int'(instr[14:12]);
    f7  = int'(instr[31:25]);
    s   = instr;
    t20 = s >>> 20;
    t25 = s >>> 25;
    t31 = s >>> 31;
    imm = 32'd0;
    legal = 1'b1;
    fmt = 7;
    case (instr[6:0])
      7'h33: begin fmt = 0; legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
      7'h13: begin
        fmt = 1; imm = t20;
        if (f3 == 1) legal = (f7 == 0);
        else if (f3 == 5) legal = (f7 == 0 || f7 == 32);
      end
      7'h03: begin fmt = 1; imm = t20; legal = f3 inside {0, 1, 2, 4, 5}; end
      7'h67: begin fmt = 1; imm = t20; legal = (f3 == 0); end
      7'h73, 7'h0f: begin fmt = 1; imm = t20; end
      7'h23: begin fmt = 2; imm = (t25 << 5) | {27'd0, instr[11:7]}; legal = (f3 < 3); end
      7'h63: begin
        fmt = 3; legal = !(f3 == 2 || f3 == 3);
        imm = (t31 << 12) | (32'(instr[7]) << 11) | (32'(instr[30:25]) << 5) | (32'(instr[11:8]) << 1);
      end
      7'h37, 7'h17: begin fmt = 4; imm = instr & 32'hFFFFF000; end
      7'h6f: begin
        fmt = 5;
        imm = (t31 << 20) | (32'(instr[19:12]) << 12) | (32'(instr[20]) << 11) | (32'(instr[30:21]) << 1);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) imm = 32'd0;
    return {pc, instr[6:0], instr[11:7], instr[14:12], instr[19:15], instr[24:20],
            instr[31:25], imm, 3'(fmt), !legal};
  endfunction

  function automatic vec_t obs1();
    return {b1.out_pc, b1.out_opcode, b1.out_rd, b1.out_funct3, b1.out_rs1, b1.out_rs2,
            b1.out_funct7, b1.out_imm, b1.out_fmt, b1.out_illegal};
  endfunction

  function automatic vec_t obs0();
    return {b0.out_pc, b0.out_opcode, b0.out_rd, b0.out_funct3, b0.out_rs1, b0.out_rs2,
            b0.out_funct7, b0.out_imm, b0.out_fmt, b0.out_illegal};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom();
    case ($urandom_range(0, 11))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h67;
      4: op = 7'h73;  5: op = 7'h0f;  6: op = 7'h23;  7: op = 7'h63;
      8: op = 7'h37;  9: op = 7'h17; 10: op = 7'h6f;
      default: op = w[6:0];
    endcase
    w[6:0] = op;
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (b1.out_valid !== 1'b0) $display("FAIL reset_valid1: got %0b want 0", b1.out_valid); else n_pass++;
    n_total++; if (obs1() !== '0) $display("FAIL reset_data1: got %h want 0", obs1()); else n_pass++;
    n_total++; if (b1.in_ready !== 1'b1) $display("FAIL reset_in_ready1: got %0b want 1", b1.in_ready); else n_pass++;
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL reset_valid0: got %0b want 0", b0.out_valid); else n_pass++;
    n_total++; if (obs0() !== '0) $display("FAIL reset_data0: got %h want 0", obs0()); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (b1.out_valid !== 1'b0) $display("FAIL post_reset_idle: got %0b want 0", b1.out_valid); else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] ins [6] = '{32'h00500093, 32'hFE20AE23, 32'h008000EF, 32'h123452B7, 32'hFFFFFFFF, 32'h40001033};
    logic [2:0]  fmt [6] = '{3'd1, 3'd2, 3'd5, 3'd4, 3'd7, 3'd0};
    logic [31:0] imm [6] = '{32'h5, 32'hFFFFFFFC, 32'h8, 32'h12345000, 32'h0, 32'h0};
    logic        ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    b1.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b1.in_valid = 1'b1;
      b1.in_instr = ins[k];
      b1.in_pc    = 32'h100 + 32'(k * 4);
      @(posedge clk); #1;
      n_total++; if (b1.out_valid !== 1'b1) $display("FAIL dir%0d_valid: got %0b want 1", k, b1.out_valid); else n_pass++;
      n_total++; if (b1.out_fmt !== fmt[k]) $display("FAIL dir%0d_fmt: got %0d want %0d", k, b1.out_fmt, fmt[k]); else n_pass++;
      n_total++; if (b1.out_imm !== imm[k]) $display("FAIL dir%0d_imm: got %h want %h", k, b1.out_imm, imm[k]); else n_pass++;
      n_total++; if (b1.out_illegal !== ill[k]) $display("FAIL dir%0d_illegal: got %0b want %0b", k, b1.out_illegal, ill[k]); else n_pass++;
      n_total++; if (obs1() !== ref_vec(ins[k], 32'h100 + 32'(k * 4))) $display("FAIL dir%0d_vec: got %h want %h", k, obs1(), ref_vec(ins[k], 32'h100 + 32'(k * 4))); else n_pass++;
      if (k == 0) begin
        n_total++; if (b1.out_rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", b1.out_rd); else n_pass++;
      end
      if (k == 1) begin
        n_total++; if (b1.out_rs1 !== 5'd1 || b1.out_rs2 !== 5'd2) $display("FAIL sw_regs: got rs1=%0d rs2=%0d want 1 2", b1.out_rs1, b1.out_rs2); else n_pass++;
      end
    end
    b1.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_ins [8];
    int acc = 0;
    int con = 0;
    bit a;
    bit c;
    for (int i = 0; i < 8; i++) e_ins[i] = rand_instr();
    for (int cyc = 0; cyc < 30 && con < 8; cyc++) begin
      b1.out_ready = (cyc >= 3);
      b1.in_valid  = (acc < 8);
      b1.in_instr  = e_ins[acc % 8];
      b1.in_pc     = 32'h2000 + 32'(acc * 4);
      @(negedge clk);
      if (cyc == 2) begin
        n_total++; if (b1.in_ready !== 1'b0) $display("FAIL bp_ready_drop: got %0b want 0", b1.in_ready); else n_pass++;
      end
      if (cyc >= 4 && cyc <= 9) begin
        n_total++; if (b1.in_ready !== 1'b1) $display("FAIL bp_ready_resume cyc%0d: got %0b want 1", cyc, b1.in_ready); else n_pass++;
      end
      if (cyc >= 1 && cyc <= 10) begin
        n_total++; if (b1.out_valid !== 1'b1) $display("FAIL bp_valid cyc%0d: got %0b want 1", cyc, b1.out_valid); else n_pass++;
      end
      if (b1.out_valid && cyc >= 1) begin
        n_total++; if (obs1() !== ref_vec(e_ins[con], 32'h2000 + 32'(con * 4))) $display("FAIL bp_order cyc%0d: got %h want %h", cyc, obs1(), ref_vec(e_ins[con], 32'h2000 + 32'(con * 4))); else n_pass++;
      end
      a = b1.in_valid && b1.in_ready;
      c = b1.out_valid && b1.out_ready;
      @(posedge clk); #1;
      if (a) acc++;
      if (c) con++;
    end
    b1.in_valid = 1'b0;
    n_total++; if (con != 8 || acc != 8) $display("FAIL bp_count: got acc=%0d con=%0d want 8 8", acc, con); else n_pass++;
  endtask

  task automatic test_flush();
    flush1 = 1'b1; flush0 = 1'b1;
    @(posedge clk); #1;
    flush1 = 1'b0; flush0 = 1'b0;
    b1.out_ready = 1'b0; b1.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b1.in_instr = rand_instr(); b1.in_pc = 32'h3000 + 32'(k * 4);
      @(posedge clk); #1;
    end
    n_total++; if (b1.in_ready !== 1'b0) $display("FAIL flush1_full: got %0b want 0", b1.in_ready); else n_pass++;
    flush1 = 1'b1;
    @(posedge clk); #1;
    flush1 = 1'b0; b1.in_valid = 1'b0;
    n_total++; if (b1.out_valid !== 1'b0) $display("FAIL flush1_valid: got %0b want 0", b1.out_valid); else n_pass++;
    n_total++; if (b1.in_ready !== 1'b1) $display("FAIL flush1_ready: got %0b want 1", b1.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (b1.out_valid !== 1'b0) $display("FAIL flush1_dropped: got %0b want 0", b1.out_valid); else n_pass++;
    b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_instr = rand_instr(); b0.in_pc = 32'h3100;
    @(posedge clk); #1;
    b0.out_ready = 1'b1; flush0 = 1'b1; b0.in_instr = rand_instr();
    @(posedge clk); #1;
    flush0 = 1'b0; b0.in_valid = 1'b0;
    n_total++; if (b0.out_valid !== 1'b0) $display("FAIL flush0_valid: got %0b want 0", b0.out_valid); else n_pass++;
    n_total++; if (b0.in_ready !== 1'b1) $display("FAIL flush0_ready: got %0b want 1", b0.in_ready); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [31:0] x;
    b1.out_ready = 1'b1; b0.out_ready = 1'b1;
    b1.in_valid = 1'b1; b0.in_valid = 1'b1;
    b1.in_instr = rand_instr(); b0.in_instr = b1.in_instr;
    b1.in_pc = 32'h4000; b0.in_pc = 32'h4000;
    @(posedge clk); #1;
    n_total++; if (b1.out_valid !== 1'b1 || b0.out_valid !== 1'b1) $display("FAIL arst_pre: got %0b %0b want 1 1", b1.out_valid, b0.out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (b1.out_valid !== 1'b0 || b0.out_valid !== 1'b0) $display("FAIL arst_valid: got %0b %0b want 0 0", b1.out_valid, b0.out_valid); else n_pass++;
    n_total++; if (obs1() !== '0) $display("FAIL arst_data: got %h want 0", obs1()); else n_pass++;
    x = rand_instr();
    b1.in_instr = x; b0.in_instr = x; b1.in_pc = 32'h4004; b0.in_pc = 32'h4004;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (b1.in_ready !== 1'b1) $display("FAIL arst_ready: got %0b want 1", b1.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (b1.out_valid !== 1'b1 || obs1() !== ref_vec(x, 32'h4004)) $display("FAIL arst_first1: got v=%0b %h want 1 %h", b1.out_valid, obs1(), ref_vec(x, 32'h4004)); else n_pass++;
    n_total++; if (b0.out_valid !== 1'b1 || obs0() !== ref_vec(x, 32'h4004)) $display("FAIL arst_first0: got v=%0b %h want 1 %h", b0.out_valid, obs0(), ref_vec(x, 32'h4004)); else n_pass++;
    b1.in_valid = 1'b0; b0.in_valid = 1'b0;
  endtask

  task automatic test_random();
    vec_t q1 [$];
    vec_t q0 [$];
    bit   r1;
    bit   r0;
    bit   a1;
    bit   a0;
    bit   c1;
    bit   c0;
    flush1 = 1'b1; flush0 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      b1.in_valid = ($urandom_range(0, 3) != 0); b1.in_instr = rand_instr(); b1.in_pc = $urandom();
      b1.out_ready = ($urandom_range(0, 2) != 0); flush1 = ($urandom_range(0, 24) == 0);
      b0.in_valid = ($urandom_range(0, 3) != 0); b0.in_instr = rand_instr(); b0.in_pc = $urandom();
      b0.out_ready = ($urandom_range(0, 2) != 0); flush0 = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      r1 = (q1.size() < 2);
      r0 = (q0.size() == 0) || b0.out_ready;
      n_total++; if (b1.out_valid !== (q1.size() > 0)) $display("FAIL rnd1_valid cyc%0d: got %0b want %0b", cyc, b1.out_valid, q1.size() > 0); else n_pass++;
      n_total++; if (b1.in_ready !== r1) $display("FAIL rnd1_ready cyc%0d: got %0b want %0b", cyc, b1.in_ready, r1); else n_pass++;
      if (q1.size() > 0) begin
        n_total++; if (obs1() !== q1[0]) $display("FAIL rnd1_data cyc%0d: got %h want %h", cyc, obs1(), q1[0]); else n_pass++;
      end
      n_total++; if (b0.out_valid !== (q0.size() > 0)) $display("FAIL rnd0_valid cyc%0d: got %0b want %0b", cyc, b0.out_valid, q0.size() > 0); else n_pass++;
      n_total++; if (b0.in_ready !== r0) $display("FAIL rnd0_ready cyc%0d: got %0b want %0b", cyc, b0.in_ready, r0); else n_pass++;
      if (q0.size() > 0) begin
        n_total++; if (obs0() !== q0[0]) $display("FAIL rnd0_data cyc%0d: got %h want %h", cyc, obs0(), q0[0]); else n_pass++;
      end
      a1 = b1.in_valid && r1;
      c1 = (q1.size() > 0) && b1.out_ready;
      a0 = b0.in_valid && r0;
      c0 = (q0.size() > 0) && b0.out_ready;
      if (flush1) q1.delete();
      else begin
        if (c1) void'(q1.pop_front());
        if (a1) q1.push_back(ref_vec(b1.in_instr, b1.in_pc));
      end
      if (flush0) q0.delete();
      else begin
        if (c0) void'(q0.pop_front());
        if (a0) q0.push_back(ref_vec(b0.in_instr, b0.in_pc));
      end
      @(posedge clk); #1;
    end
    flush1 = 1'b0; flush0 = 1'b0;
    b1.in_valid = 1'b0; b0.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush1 = 1'b0; flush0 = 1'b0;
    b1.in_valid = 1'b0; b1.in_instr = '0; b1.in_pc = '0; b1.out_ready = 1'b1;
    b0.in_valid = 1'b0; b0.in_instr = '0; b0.in_pc = '0; b0.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
